// File: rtl/midi_note_parser.sv
// ============================================================================
// Module   : midi_note_parser
// Purpose  : MIDI byte stream to monophonic note/velocity/gate/program controls
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_note_parser #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic [6:0] NOTE_NUM,
    output logic [6:0] NOTE_VEL,
    output logic       GATE,
    output logic [6:0] PROGRAM,
    output logic       NOTE_STROBE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] run_status_q, run_status_d;
    logic       run_ok_q, run_ok_d;
    logic [6:0] d1_q, d1_d;
    logic [6:0] note_num_q, note_num_d;
    logic [6:0] note_vel_q, note_vel_d;
    logic       gate_q, gate_d;
    logic [6:0] program_q, program_d;
    logic       strobe_q, strobe_d;

    logic       w_is_realtime;
    logic       w_is_system;
    logic       w_is_status;
    logic       w_one_data;
    logic       w_qualify;
    logic       w_msg_done;
    logic [6:0] w_msg_d1;
    logic [6:0] w_msg_d2;

    assign w_is_realtime = (RX_DATA[7:3] == 5'b11111);
    assign w_is_system   = (RX_DATA[7:4] == 4'hF) && !w_is_realtime;
    assign w_is_status   = RX_DATA[7] && !w_is_system && !w_is_realtime;
    assign w_one_data    = (run_status_q[7:4] == 4'hC) || (run_status_q[7:4] == 4'hD);
    assign w_qualify     = OMNI || (run_status_q[3:0] == CHANNEL);

    always_comb begin
        state_d      = state_q;
        run_status_d = run_status_q;
        run_ok_d     = run_ok_q;
        d1_d         = d1_q;
        w_msg_done   = 1'b0;
        w_msg_d1     = d1_q;
        w_msg_d2     = 7'd0;

        // Realtime bytes fall through every branch so they never disturb a message
        if (RX_VALID) begin
            if (w_is_system) begin
                run_ok_d = 1'b0;
                state_d  = IDLE;
            end else if (w_is_status) begin
                run_status_d = RX_DATA;
                run_ok_d     = 1'b1;
                state_d      = WAIT_D1;
            end else if (!RX_DATA[7]) begin
                case (state_q)
                    WAIT_D1: begin
                        d1_d = RX_DATA[6:0];
                        if (w_one_data) begin
                            w_msg_done = run_ok_q;
                            w_msg_d1   = RX_DATA[6:0];
                        end else begin
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        w_msg_done = run_ok_q;
                        w_msg_d2   = RX_DATA[6:0];
                        state_d    = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        note_num_d = note_num_q;
        note_vel_d = note_vel_q;
        gate_d     = gate_q;
        program_d  = program_q;
        strobe_d   = 1'b0;

        if (w_msg_done && w_qualify) begin
            case (run_status_q[7:4])
                4'h9, 4'h8: begin
                    if ((run_status_q[7:4] == 4'h9) && (w_msg_d2 != 7'd0)) begin
                        note_num_d = w_msg_d1;
                        note_vel_d = w_msg_d2;
                        gate_d     = 1'b1;
                        strobe_d   = 1'b1;
                    end else if (gate_q && (w_msg_d1 == note_num_q)) begin
                        // Release only the sounding key; stale note-offs are dropped
                        gate_d   = 1'b0;
                        strobe_d = 1'b1;
                    end
                end
                4'hC:    program_d = w_msg_d1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= IDLE;
            run_status_q <= 8'd0;
            run_ok_q     <= 1'b0;
            d1_q         <= 7'd0;
            note_num_q   <= 7'd0;
            note_vel_q   <= 7'd0;
            gate_q       <= 1'b0;
            program_q    <= 7'd0;
            strobe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_status_q <= run_status_d;
            run_ok_q     <= run_ok_d;
            d1_q         <= d1_d;
            note_num_q   <= note_num_d;
            note_vel_q   <= note_vel_d;
            gate_q       <= gate_d;
            program_q    <= program_d;
            strobe_q     <= strobe_d;
        end
    end

    assign NOTE_NUM    = note_num_q;
    assign NOTE_VEL    = note_vel_q;
    assign GATE        = gate_q;
    assign PROGRAM     = program_q;
    assign NOTE_STROBE = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_midi_note_parser.sv
// ============================================================================
// Module   : tb_midi_note_parser
// Purpose  : randomized and directed bench for midi_note_parser (OMNI off/on)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_midi_note_parser;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [7:0] RX_DATA;
    logic       RX_VALID;

    logic [6:0] note_num [2];
    logic [6:0] note_vel [2];
    logic [6:0] prog     [2];
    logic       gate     [2];
    logic       strobe   [2];

    // Instance 0 listens to channel 0 only, instance 1 is omni
    generate
        for (genvar k = 0; k < 2; k++) begin : g_dut
            midi_note_parser #(.CHANNEL(4'd0), .OMNI(k == 1)) u_dut (
                .CLK        (CLK),
                .RSTN       (RSTN),
                .RX_DATA    (RX_DATA),
                .RX_VALID   (RX_VALID),
                .NOTE_NUM   (note_num[k]),
                .NOTE_VEL   (note_vel[k]),
                .GATE       (gate[k]),
                .PROGRAM    (prog[k]),
                .NOTE_STROBE(strobe[k])
            );
        end
    endgenerate

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: running status plus a queue of collected data bytes
    int         m_rs;
    logic [7:0] m_q [$];
    logic [6:0] e_num [2];
    logic [6:0] e_vel [2];
    logic [6:0] e_prog [2];
    logic       e_gate [2];
    logic       e_pulse [2];
    int         e_cnt [2] = '{0, 0};
    int         o_cnt [2] = '{0, 0};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_num[k] = 0; e_vel[k] = 0; e_prog[k] = 0; e_gate[k] = 0; e_pulse[k] = 0;
        end
        m_rs = -1;
        m_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int need, hi;
        logic [6:0] d1, d2;
        e_pulse[0] = 0;
        e_pulse[1] = 0;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin m_rs = -1; m_q.delete(); return; end
        if (b >= 8'h80) begin m_rs = int'(b); m_q.delete(); return; end
        if (m_rs < 0) return;
        m_q.push_back(b);
        hi   = m_rs / 16;
        need = (hi == 12 || hi == 13) ? 1 : 2;
        if (m_q.size() < need) return;
        d1 = m_q[0][6:0];
        d2 = (need == 2) ? m_q[1][6:0] : 7'd0;
        m_q.delete();
        for (int k = 0; k < 2; k++) begin
            if (k == 1 || (m_rs % 16) == 0) begin
                if (hi == 9 && d2 != 0) begin
                    e_num[k] = d1; e_vel[k] = d2; e_gate[k] = 1;
                    e_pulse[k] = 1; e_cnt[k]++;
                end else if (hi == 9 || hi == 8) begin
                    if (e_gate[k] && d1 == e_num[k]) begin
                        e_gate[k] = 0; e_pulse[k] = 1; e_cnt[k]++;
                    end
                end else if (hi == 12) begin
                    e_prog[k] = d1;
                end
            end
        end
    endtask

    task automatic apply_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(posedge CLK);
        #1;
        model_byte(b);
        for (int k = 0; k < 2; k++) if (strobe[k]) o_cnt[k]++;
    endtask

    task automatic idle(input int n);
        RX_VALID = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
            e_pulse[0] = 0;
            e_pulse[1] = 0;
            for (int k = 0; k < 2; k++) if (strobe[k]) o_cnt[k]++;
        end
    endtask

    task automatic send(input logic [7:0] bytes [$]);
        foreach (bytes[i]) apply_byte(bytes[i]);
        idle(1);
    endtask

    task automatic test_reset();
        RSTN = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
        model_reset();
        #23;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({note_num[k], note_vel[k], gate[k], prog[k], strobe[k]} !== 23'd0) begin
                miscompares++;
                $display("FAIL reset[%0d]: got num=%h vel=%h gate=%b prog=%h strb=%b, want all zero",
                         k, note_num[k], note_vel[k], gate[k], prog[k], strobe[k]);
            end
        end
        @(negedge CLK);
        RSTN = 1'b1;
        idle(1);
    endtask

    task automatic test_note_on();
        int c0 = o_cnt[0];
        send('{8'h90, 8'h45, 8'h64});
        vectors++;
        if (note_num[0] !== 7'h45 || note_vel[0] !== 7'h64 || gate[0] !== 1'b1 || o_cnt[0] - c0 != 1) begin
            miscompares++;
            $display("FAIL note_on: got num=%h vel=%h gate=%b strobes=%0d, want 45 64 1 1",
                     note_num[0], note_vel[0], gate[0], o_cnt[0] - c0);
        end
    endtask

    task automatic test_running_status();
        int c0 = o_cnt[0];
        send('{8'h90, 8'h3C, 8'h40, 8'h3C, 8'h00});
        vectors++;
        if (note_num[0] !== 7'h3C || gate[0] !== 1'b0 || o_cnt[0] - c0 != 2) begin
            miscompares++;
            $display("FAIL running_status: got num=%h gate=%b strobes=%0d, want 3c 0 2",
                     note_num[0], gate[0], o_cnt[0] - c0);
        end
    endtask

    task automatic test_note_off_other();
        int c0 = o_cnt[0];
        send('{8'h90, 8'h40, 8'h50, 8'h80, 8'h41, 8'h00});
        vectors++;
        if (gate[0] !== 1'b1 || o_cnt[0] - c0 != 1) begin
            miscompares++;
            $display("FAIL off_other_key: got gate=%b strobes=%0d, want 1 1", gate[0], o_cnt[0] - c0);
        end
        send('{8'h80, 8'h40, 8'h00});
        vectors++;
        if (gate[0] !== 1'b0 || note_num[0] !== 7'h40 || o_cnt[0] - c0 != 2) begin
            miscompares++;
            $display("FAIL off_same_key: got gate=%b num=%h strobes=%0d, want 0 40 2",
                     gate[0], note_num[0], o_cnt[0] - c0);
        end
    endtask

    task automatic test_interleave();
        int c0;
        send('{8'h90, 8'h40, 8'hF8, 8'h50});
        vectors++;
        if (note_num[0] !== 7'h40 || note_vel[0] !== 7'h50 || gate[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL realtime_mid: got num=%h vel=%h gate=%b, want 40 50 1",
                     note_num[0], note_vel[0], gate[0]);
        end
        c0 = o_cnt[0];
        send('{8'h80, 8'h40, 8'h00, 8'h90, 8'h41, 8'hF0, 8'h50});
        vectors++;
        if (note_num[0] !== 7'h40 || gate[0] !== 1'b0 || o_cnt[0] - c0 != 1) begin
            miscompares++;
            $display("FAIL sysex_mid: got num=%h gate=%b strobes=%0d, want 40 0 1",
                     note_num[0], gate[0], o_cnt[0] - c0);
        end
    endtask

    task automatic test_channel_filter();
        int c0 = o_cnt[0];
        int c1 = o_cnt[1];
        send('{8'h91, 8'h40, 8'h50, 8'hC0, 8'h05});
        vectors++;
        if (gate[0] !== 1'b0 || prog[0] !== 7'h05 || o_cnt[0] - c0 != 0) begin
            miscompares++;
            $display("FAIL filter_ch0: got gate=%b prog=%h strobes=%0d, want 0 05 0",
                     gate[0], prog[0], o_cnt[0] - c0);
        end
        vectors++;
        if (gate[1] !== 1'b1 || note_num[1] !== 7'h40 || prog[1] !== 7'h05 || o_cnt[1] - c1 != 1) begin
            miscompares++;
            $display("FAIL filter_omni: got gate=%b num=%h prog=%h strobes=%0d, want 1 40 05 1",
                     gate[1], note_num[1], prog[1], o_cnt[1] - c1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [7] = '{8'h90, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        for (int i = 0; i < 7; i++) begin
            apply_byte(seq[i]);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (strobe[k] !== e_pulse[k] || note_num[k] !== e_num[k] || note_vel[k] !== e_vel[k]) begin
                    miscompares++;
                    $display("FAIL back_to_back[%0d] byte %0d: got strb=%b num=%h vel=%h, want %b %h %h",
                             k, i, strobe[k], note_num[k], note_vel[k], e_pulse[k], e_num[k], e_vel[k]);
                end
            end
        end
        idle(1);
        vectors++;
        if (note_num[0] !== 7'h34 || note_vel[0] !== 7'h35 || gate[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back_final: got num=%h vel=%h gate=%b, want 34 35 1",
                     note_num[0], note_vel[0], gate[0]);
        end
    endtask

    task automatic test_reset_mid();
        send('{8'h90, 8'h40});
        RSTN = 1'b0;
        #3;
        model_reset();
        vectors++;
        if ({note_num[0], note_vel[0], gate[0], prog[0], strobe[0]} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_async: got num=%h vel=%h gate=%b prog=%h strb=%b, want all zero",
                     note_num[0], note_vel[0], gate[0], prog[0], strobe[0]);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        begin
            int c0 = o_cnt[0];
            send('{8'h50});
            vectors++;
            if ({note_num[0], note_vel[0], gate[0]} !== 15'd0 || o_cnt[0] - c0 != 0) begin
                miscompares++;
                $display("FAIL reset_mid: got num=%h vel=%h gate=%b strobes=%0d, want 0 0 0 0",
                         note_num[0], note_vel[0], gate[0], o_cnt[0] - c0);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(9))
                0:       b = 8'hF8 + 8'($urandom_range(7));
                1:       b = 8'hF0 + 8'($urandom_range(7));
                2, 3:    b = {1'b1, 3'($urandom_range(6)), 4'($urandom_range(1))};
                4:       b = 8'h00;
                default: b = 8'h3C + 8'($urandom_range(3));
            endcase
            if ($urandom_range(9) == 0) idle(1);
            apply_byte(b);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if ({note_num[k], note_vel[k], gate[k], prog[k], strobe[k]} !==
                    {e_num[k], e_vel[k], e_gate[k], e_prog[k], e_pulse[k]}) begin
                    miscompares++;
                    $display("FAIL random[%0d] byte %0d (%h): got num=%h vel=%h gate=%b prog=%h strb=%b, want %h %h %b %h %b",
                             k, i, b, note_num[k], note_vel[k], gate[k], prog[k], strobe[k],
                             e_num[k], e_vel[k], e_gate[k], e_prog[k], e_pulse[k]);
                end
            end
        end
        idle(2);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (o_cnt[k] != e_cnt[k]) begin
                miscompares++;
                $display("FAIL strobe_total[%0d]: got %0d, want %0d", k, o_cnt[k], e_cnt[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_note_off_other();
        test_interleave();
        test_channel_filter();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/midi_note_parser.md
# midi_note_parser

Parses a MIDI byte stream from the serial receiver into the monophonic note controls consumed by the `nco` voice: note number, velocity, gate and program. It sits directly upstream of the oscillator. It decodes channel-voice messages for one configurable channel, tracks running status, and discards everything else without disturbing the parse. All outputs are registered and held until the next qualifying message.

## Interface
- `CHANNEL`, default 0: MIDI channel (0–15) this voice responds to.
- `OMNI`, default 0: when 1, responds to all channels and `CHANNEL` is ignored.
- `CLK` in 1: system clock, 100 MHz.
- `RSTN` in 1: reset. One clock domain; reset is asynchronous and active-low.
- `RX_DATA` in 8: received byte; valid only when `RX_VALID`=1.
- `RX_VALID` in 1: one-cycle pulse per received byte. Back-to-back pulses are legal.
- `NOTE_NUM` out 7: current note number.
- `NOTE_VEL` out 7: velocity of current note.
- `GATE` out 1: 1 while the current note is held.
- `PROGRAM` out 7: last program number received.
- `NOTE_STROBE` out 1: one-cycle pulse whenever `NOTE_NUM`, `NOTE_VEL` or `GATE` is written, including writes of unchanged values.

## Operation
- Byte classes:
  - Status: bit7=1.
  - Data: bit7=0.
  - Realtime: 0xF8–0xFF.
  - System common/exclusive: 0xF0–0xF7.
- Registered parse state:
  - `run_status[7:0]`, valid flag `run_ok`.
  - FSM state ∈ {IDLE, WAIT_D1, WAIT_D2}.
  - `d1[6:0]`.
- Realtime byte: ignored completely in every state. FSM, running status and outputs are unchanged.
- System byte 0xF0–0xF7: clears `run_ok`, FSM → IDLE. Following data bytes (sysex payload) are ignored until the next channel status byte.
- Channel status byte 0x80–0xEF: latched into `run_status`, `run_ok`=1, FSM → WAIT_D1. Any partially received message is aborted.
- Data byte in IDLE: ignored.
- Data byte in WAIT_D1: stored in `d1`.
  - If `run_status[7:4]` is 0xC or 0xD (one data byte), the message completes and the FSM stays in WAIT_D1 (running status).
  - Otherwise the FSM → WAIT_D2.
- Data byte in WAIT_D2: the message completes; FSM → WAIT_D1 (running status).
- A message qualifies when `OMNI`=1 or `run_status[3:0]`=`CHANNEL`. Actions on completion of a qualifying message:
  - 0x9n with d2≠0: `NOTE_NUM`←d1, `NOTE_VEL`←d2, `GATE`←1, strobe.
  - 0x9n with d2=0, or 0x8n (any velocity): if d1=`NOTE_NUM` and `GATE`=1, then `GATE`←0 and strobe; `NOTE_NUM`/`NOTE_VEL` are unchanged. Otherwise no action.
  - 0xCn: `PROGRAM`←d1. No strobe.
  - 0xAn, 0xBn, 0xDn, 0xEn: consumed, no action.
- A non-qualifying channel still runs the FSM and running status, with no output effect.
- Note priority: last note on wins. A new Note On while the gate is high retriggers (strobe, gate stays 1).

## Timing
- Reset (async assert, sync-released use) values:
  - `NOTE_NUM`=0, `NOTE_VEL`=0, `GATE`=0, `PROGRAM`=0, `NOTE_STROBE`=0.
  - FSM=IDLE, `run_ok`=0.
- Output latency: outputs update on the same `CLK` edge that samples the completing `RX_VALID`. `NOTE_STROBE` is high for exactly the following cycle.
- `RX_VALID` on consecutive cycles: each byte is processed in its own cycle; there is no backpressure and no byte loss.
- `RSTN` asserted mid-message: the partial message is discarded, outputs return to reset values immediately, and running status is lost.
- `NOTE_STROBE` is never high for two consecutive cycles unless two messages complete on consecutive cycles.

## Test plan
- Reset, then bytes 0x90 0x45 0x64: `NOTE_NUM`=0x45, `NOTE_VEL`=0x64, `GATE`=1, one strobe on the third byte's edge.
- Running status: 0x90 0x3C 0x40 0x3C 0x00: `GATE`=1, then `GATE`=0 with `NOTE_NUM`=0x3C; two strobes.
- Note Off for a different key: 0x90 0x40 0x50 then 0x80 0x41 0x00: `GATE` stays 1, second message gives no strobe. A following 0x80 0x40 0x00 gives `GATE`=0.
- Interleaving: 0x90 0x40 0xF8 0x50 (realtime mid-message) gives the note on with `VEL`=0x50. 0x90 0x40 0xF0 0x50 gives no change.
- Channel filter with `CHANNEL`=0, `OMNI`=0: 0x91 0x40 0x50 gives no output change. 0xC0 0x05 gives `PROGRAM`=5 and no strobe. Repeat with `OMNI`=1: 0x91 message sets `GATE`=1.
- Reset mid-message: 0x90 0x40, pulse `RSTN` low, then 0x50: outputs stay at reset values and no strobe.
